// File: rtl/descriptor_fetch_pkg.sv
// Shared constants and types for the descriptor fetch master: descriptor word
// layout, control-word bit positions and the fetch FSM state encoding.
package descriptor_fetch_pkg;

    localparam int OFF_SRC  = 0;
    localparam int OFF_DST  = 4;
    localparam int OFF_NEXT = 8;
    localparam int OFF_CTRL = 12;

    localparam int CTRL_OWNED = 31;
    localparam int CTRL_LAST  = 30;

    localparam int DESC_WORDS = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        CHECK,
        PRESENT,
        WB,
        NEXT
    } state_t;

    // Descriptors live on 16-byte boundaries.
    function automatic logic ptr_aligned(input logic [3:0] low_bits);
        return low_bits == 4'h0;
    endfunction

endpackage

// File: rtl/descriptor_fetch_master_if.sv
// Avalon-MM master port plus the descriptor valid/ready stream, bundled so the
// fetch master and its environment connect through one interface.
interface descriptor_fetch_master_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
);
    logic [ADDR_W-1:0] m_address;
    logic              m_read;
    logic              m_write;
    logic [3:0]        m_byteenable;
    logic [31:0]       m_writedata;
    logic [31:0]       m_readdata;
    logic              m_readdatavalid;
    logic              m_waitrequest;

    logic              desc_valid;
    logic              desc_ready;
    logic [ADDR_W-1:0] desc_src;
    logic [ADDR_W-1:0] desc_dst;
    logic [LEN_W-1:0]  desc_len;
    logic              desc_last;

    modport master (
        output m_address, m_read, m_write, m_byteenable, m_writedata,
        input  m_readdata, m_readdatavalid, m_waitrequest,
        output desc_valid, desc_src, desc_dst, desc_len, desc_last,
        input  desc_ready
    );

    modport slave (
        input  m_address, m_read, m_write, m_byteenable, m_writedata,
        output m_readdata, m_readdatavalid, m_waitrequest,
        input  desc_valid, desc_src, desc_dst, desc_len, desc_last,
        output desc_ready
    );
endinterface

// File: rtl/descriptor_fetch_master_desc_capture_regs.sv
// Four-word capture register file for one descriptor, written in response order,
// with the stream fields and chain-control bits extracted combinationally.
module desc_capture_regs
    import descriptor_fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [1:0]        wr_idx,
    input  logic [31:0]       wr_data,
    output logic [ADDR_W-1:0] src,
    output logic [ADDR_W-1:0] dst,
    output logic [ADDR_W-1:0] next_ptr,
    output logic [31:0]       ctrl,
    output logic [LEN_W-1:0]  len,
    output logic              last,
    output logic              owned
);

    logic [31:0] words [DESC_WORDS];

    // NOTE: this register file is tiny, so it is reset like any other state;
    // the descriptor outputs then read as zero rather than X after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DESC_WORDS; i++) words[i] <= '0;
        end else if (wr_en) begin
            words[wr_idx] <= wr_data;
        end
    end

    assign src      = ADDR_W'(words[OFF_SRC / 4]);
    assign dst      = ADDR_W'(words[OFF_DST / 4]);
    assign next_ptr = ADDR_W'(words[OFF_NEXT / 4]);
    assign ctrl     = words[OFF_CTRL / 4];
    assign len      = ctrl[LEN_W-1:0];
    assign last     = ctrl[CTRL_LAST];
    assign owned    = ctrl[CTRL_OWNED];

endmodule

// File: rtl/descriptor_fetch_master.sv
// Avalon-MM descriptor chain walker: fetches 4-word descriptors, hands them to the
// DMA datapath over valid/ready, writes back the control word with OWNED cleared.
module descriptor_fetch_master
    import descriptor_fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_ptr,
    input  logic              stop_req,
    output logic              busy,
    output logic              done,
    output logic              error,
    descriptor_fetch_master_if.master bus
);

    state_t            state;
    logic [ADDR_W-1:0] cur_ptr;
    logic [1:0]        iss_cnt;
    logic [1:0]        rsp_cnt;
    logic              cap_en;
    logic [ADDR_W-1:0] next_ptr;
    logic [31:0]       ctrl_word;
    logic              is_last;
    logic              owned;

    // Responses outside a fetch (e.g. stragglers after reset) are dropped.
    assign cap_en = bus.m_readdatavalid && (state == RD_ISSUE || state == RD_WAIT);

    desc_capture_regs #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_capture (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (cap_en),
        .wr_idx   (rsp_cnt),
        .wr_data  (bus.m_readdata),
        .src      (bus.desc_src),
        .dst      (bus.desc_dst),
        .next_ptr (next_ptr),
        .ctrl     (ctrl_word),
        .len      (bus.desc_len),
        .last     (is_last),
        .owned    (owned)
    );

    assign bus.desc_last = is_last;

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // read in this block sees the pre-edge value, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            cur_ptr          <= '0;
            iss_cnt          <= '0;
            rsp_cnt          <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
            bus.m_address    <= '0;
            bus.m_read       <= 1'b0;
            bus.m_write      <= 1'b0;
            bus.m_byteenable <= 4'hF;
            bus.m_writedata  <= '0;
            bus.desc_valid   <= 1'b0;
        end else begin
            done             <= 1'b0;
            error            <= 1'b0;
            bus.m_byteenable <= 4'hF;
            if (cap_en) rsp_cnt <= rsp_cnt + 2'd1;

            case (state)
                IDLE: begin
                    if (start) begin
                        if (ptr_aligned(first_ptr[3:0])) begin
                            cur_ptr       <= first_ptr;
                            bus.m_address <= first_ptr;
                            bus.m_read    <= 1'b1;
                            iss_cnt       <= '0;
                            rsp_cnt       <= '0;
                            busy          <= 1'b1;
                            state         <= RD_ISSUE;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end

                // Address advances only on an accepted read; it holds while stalled.
                RD_ISSUE: begin
                    if (!bus.m_waitrequest) begin
                        iss_cnt <= iss_cnt + 2'd1;
                        if (iss_cnt == 2'd3) begin
                            bus.m_read <= 1'b0;
                            state      <= RD_WAIT;
                        end else begin
                            bus.m_address <= bus.m_address + ADDR_W'(4);
                        end
                    end
                end

                RD_WAIT: begin
                    if (cap_en && rsp_cnt == 2'd3) state <= CHECK;
                end

                CHECK: begin
                    if (!owned) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        bus.desc_valid <= 1'b1;
                        state          <= PRESENT;
                    end
                end

                PRESENT: begin
                    if (bus.desc_ready) begin
                        bus.desc_valid  <= 1'b0;
                        bus.m_write     <= 1'b1;
                        bus.m_address   <= cur_ptr + ADDR_W'(OFF_CTRL);
                        bus.m_writedata <= ctrl_word & ~(32'h1 << CTRL_OWNED);
                        state           <= WB;
                    end
                end

                WB: begin
                    if (!bus.m_waitrequest) begin
                        bus.m_write <= 1'b0;
                        state       <= NEXT;
                    end
                end

                NEXT: begin
                    if (is_last || stop_req) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (!ptr_aligned(next_ptr[3:0])) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cur_ptr       <= next_ptr;
                        bus.m_address <= next_ptr;
                        bus.m_read    <= 1'b1;
                        iss_cnt       <= '0;
                        rsp_cnt       <= '0;
                        state         <= RD_ISSUE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_descriptor_fetch_master.sv
// Scoreboard bench for descriptor_fetch_master: directed descriptor chains against
// a word-addressed Avalon memory model with optional stalls and response delay.
module tb_descriptor_fetch_master;

    localparam int ADDR_W = 32;
    localparam int LEN_W  = 16;

    logic              clk       = 1'b0;
    logic              reset     = 1'b1;
    logic              start     = 1'b0;
    logic              stop_req  = 1'b0;
    logic [ADDR_W-1:0] first_ptr = '0;
    logic              busy;
    logic              done;
    logic              error;

    descriptor_fetch_master_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    descriptor_fetch_master #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .first_ptr (first_ptr),
        .stop_req  (stop_req),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef enum {EV_RD, EV_DESC, EV_WR, EV_DONE, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic        d;
    } ev_t;
    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_t;

    ev_t         exp_q[$];
    rsp_t        pend[$];
    logic [31:0] mem [64];
    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    bit          rand_mode   = 1'b0;
    int          fixed_dly   = 0;
    bit          inject      = 1'b0;
    logic [31:0] inject_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_desc(input logic [31:0] base, input logic [31:0] src, input logic [31:0] dst,
                            input logic [31:0] nxt, input logic [31:0] ctrl);
        mem[base[7:2]]         = src;
        mem[base[7:2] + 6'd1]  = dst;
        mem[base[7:2] + 6'd2]  = nxt;
        mem[base[7:2] + 6'd3]  = ctrl;
    endtask

    task automatic push_ev(input ev_kind_t k, input logic [31:0] pa, input logic [31:0] pb,
                           input logic [31:0] pc, input logic pd);
        exp_q.push_back('{kind: k, a: pa, b: pb, c: pc, d: pd});
    endtask

    task automatic push_reads(input logic [31:0] base);
        for (int i = 0; i < 4; i++) push_ev(EV_RD, base + 32'(4 * i), 32'hF, 32'h0, 1'b0);
    endtask

    // Expected write-back: byteenable must also be all lanes.
    task automatic push_wr(input logic [31:0] addr, input logic [31:0] data);
        push_ev(EV_WR, addr, data, 32'hF, 1'b0);
    endtask

    task automatic observe(input ev_kind_t k, input logic [31:0] oa, input logic [31:0] ob,
                           input logic [31:0] oc, input logic od, input string name);
        ev_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: got unexpected %s a=%h b=%h c=%h d=%b, required no event",
                     name, k.name(), oa, ob, oc, od);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != k || e.a !== oa || e.b !== ob || e.c !== oc || e.d !== od) begin
            miscompares++;
            $display("FAIL %s: got %s a=%h b=%h c=%h d=%b, required %s a=%h b=%h c=%h d=%b",
                     name, k.name(), oa, ob, oc, od, e.kind.name(), e.a, e.b, e.c, e.d);
        end
    endtask

    // While a descriptor is held, its fields must match the pending expectation.
    task automatic hold_check();
        logic [31:0] len32;
        len32 = 32'(bus.desc_len);
        vectors++;
        if (exp_q.size() == 0 || exp_q[0].kind != EV_DESC) begin
            miscompares++;
            $display("FAIL desc_hold: got desc_valid with src=%h, required no descriptor", bus.desc_src);
        end else if (exp_q[0].a !== bus.desc_src || exp_q[0].b !== bus.desc_dst ||
                     exp_q[0].c !== len32 || exp_q[0].d !== bus.desc_last) begin
            miscompares++;
            $display("FAIL desc_hold: got src=%h dst=%h len=%h last=%b, required src=%h dst=%h len=%h last=%b",
                     bus.desc_src, bus.desc_dst, len32, bus.desc_last,
                     exp_q[0].a, exp_q[0].b, exp_q[0].c, exp_q[0].d);
        end
    endtask

    // Monitor: compares every DUT-side event against the scoreboard queue.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (bus.m_read && !bus.m_waitrequest)
                observe(EV_RD, bus.m_address, 32'(bus.m_byteenable), 32'h0, 1'b0, "read_issue");
            if (bus.desc_valid) begin
                if (bus.desc_ready)
                    observe(EV_DESC, bus.desc_src, bus.desc_dst, 32'(bus.desc_len), bus.desc_last, "desc_accept");
                else
                    hold_check();
            end
            if (bus.m_write && !bus.m_waitrequest)
                observe(EV_WR, bus.m_address, bus.m_writedata, 32'(bus.m_byteenable), 1'b0, "writeback");
            if (done)  observe(EV_DONE, 32'h0, 32'h0, 32'h0, 1'b0, "done_pulse");
            if (error) observe(EV_ERR, 32'h0, 32'h0, 32'h0, 1'b0, "error_pulse");
        end
    end

    // Memory slave, sampling side: accept reads/writes, flush on shared reset.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            pend.delete();
        end else begin
            if (bus.m_read && !bus.m_waitrequest)
                pend.push_back('{data: mem[bus.m_address[7:2]],
                                 due: cyc + 1 + (rand_mode ? int'($urandom_range(0, 3)) : fixed_dly)});
            if (bus.m_write && !bus.m_waitrequest)
                mem[bus.m_address[7:2]] = bus.m_writedata;
        end
    end

    // Memory slave, driving side: in-order responses and waitrequest.
    initial begin
        bus.m_readdata      = '0;
        bus.m_readdatavalid = 1'b0;
        bus.m_waitrequest   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            bus.m_readdatavalid = 1'b0;
            if (inject) begin
                bus.m_readdatavalid = 1'b1;
                bus.m_readdata      = inject_data;
            end else if (pend.size() > 0 && pend[0].due <= cyc) begin
                bus.m_readdatavalid = 1'b1;
                bus.m_readdata      = pend.pop_front().data;
            end
            bus.m_waitrequest = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    task automatic pulse_start(input logic [31:0] ptr);
        start     = 1'b1;
        first_ptr = ptr;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_desc_valid(input string name);
        int n = 0;
        while (!bus.desc_valid && n < 60) begin
            tick();
            n++;
        end
        check(name, 32'(n < 60), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            tick();
            n++;
        end
        check({name, "_complete"}, 32'(n < 300), 32'd1);
        exp_q.delete();
        repeat (6) tick();
        check({name, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},       32'(busy),             32'd0);
        check({tag, "_done"},       32'(done),             32'd0);
        check({tag, "_error"},      32'(error),            32'd0);
        check({tag, "_m_read"},     32'(bus.m_read),       32'd0);
        check({tag, "_m_write"},    32'(bus.m_write),      32'd0);
        check({tag, "_desc_valid"}, 32'(bus.desc_valid),   32'd0);
        check({tag, "_byteenable"}, 32'(bus.m_byteenable), 32'hF);
        check({tag, "_m_address"},  bus.m_address,         32'h0);
        check({tag, "_writedata"},  bus.m_writedata,       32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bus.desc_ready = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        put_desc(32'h000, 32'h0000_1000, 32'h0000_2000, 32'h0000_0010, 32'hC000_0040);
        put_desc(32'h010, 32'h0000_1200, 32'h0000_2200, 32'h0000_0FF0, 32'hC000_0030);
        put_desc(32'h020, 32'h0000_3000, 32'h0000_4000, 32'h0000_0000, 32'h0000_0010);
        put_desc(32'h030, 32'h0000_5000, 32'h0000_6000, 32'h0000_0014, 32'h8000_0008);
        put_desc(32'h040, 32'hA0A0_0001, 32'hB0B0_0002, 32'h0000_0080, 32'h8000_1234);
        put_desc(32'h080, 32'hA0A0_0003, 32'hB0B0_0004, 32'h0000_0000, 32'hC000_FFFF);
        put_desc(32'h0C0, 32'h0000_7000, 32'h0000_8000, 32'h0000_00D0, 32'h8000_0004);

        reset = 1'b1;
        repeat (3) tick();
        check_reset_outputs("por");
        reset = 1'b0;
        tick();

        // 1: single LAST descriptor, start-to-valid latency.
        push_reads(32'h000);
        push_ev(EV_DESC, 32'h1000, 32'h2000, 32'h40, 1'b1);
        push_wr(32'h00C, 32'h4000_0040);
        push_ev(EV_DONE, 32'h0, 32'h0, 32'h0, 1'b0);
        pulse_start(32'h000);
        check("t1_busy_after_start", 32'(busy), 32'd1);
        n = 1;
        while (!bus.desc_valid && n < 20) begin
            tick();
            n++;
        end
        check("t1_latency", 32'(n), 32'd7);
        wait_idle("t1");

        // 2: two-descriptor chain, consumer stalls the first; a start while busy is ignored.
        put_desc(32'h000, 32'h0000_1100, 32'h0000_2100, 32'h0000_0010, 32'h8000_0020);
        push_reads(32'h000);
        push_ev(EV_DESC, 32'h1100, 32'h2100, 32'h20, 1'b0);
        push_wr(32'h00C, 32'h0000_0020);
        push_reads(32'h010);
        push_ev(EV_DESC, 32'h1200, 32'h2200, 32'h30, 1'b1);
        push_wr(32'h01C, 32'h4000_0030);
        push_ev(EV_DONE, 32'h0, 32'h0, 32'h0, 1'b0);
        bus.desc_ready = 1'b0;
        pulse_start(32'h000);
        pulse_start(32'h008);
        wait_desc_valid("t2_first_valid");
        repeat (5) tick();
        bus.desc_ready = 1'b1;
        wait_idle("t2");

        // 3: random stalls and response delay across a two-descriptor chain.
        rand_mode = 1'b1;
        push_reads(32'h040);
        push_ev(EV_DESC, 32'hA0A0_0001, 32'hB0B0_0002, 32'h1234, 1'b0);
        push_wr(32'h04C, 32'h0000_1234);
        push_reads(32'h080);
        push_ev(EV_DESC, 32'hA0A0_0003, 32'hB0B0_0004, 32'hFFFF, 1'b1);
        push_wr(32'h08C, 32'h4000_FFFF);
        push_ev(EV_DONE, 32'h0, 32'h0, 32'h0, 1'b0);
        pulse_start(32'h040);
        wait_idle("t3");
        rand_mode = 1'b0;

        // 4: not owned by hardware: four reads then done, nothing presented or written.
        push_reads(32'h020);
        push_ev(EV_DONE, 32'h0, 32'h0, 32'h0, 1'b0);
        pulse_start(32'h020);
        wait_idle("t4");

        // 5: misaligned next pointer after write-back, then misaligned start.
        push_reads(32'h030);
        push_ev(EV_DESC, 32'h5000, 32'h6000, 32'h8, 1'b0);
        push_wr(32'h03C, 32'h0000_0008);
        push_ev(EV_ERR, 32'h0, 32'h0, 32'h0, 1'b0);
        pulse_start(32'h030);
        wait_idle("t5a");
        push_ev(EV_ERR, 32'h0, 32'h0, 32'h0, 1'b0);
        pulse_start(32'h008);
        check("t5_busy_after_bad_start", 32'(busy), 32'd0);
        wait_idle("t5b");

        // 6: stop_req during PRESENT still writes back, then done.
        push_reads(32'h0C0);
        push_ev(EV_DESC, 32'h7000, 32'h8000, 32'h4, 1'b0);
        push_wr(32'h0CC, 32'h0000_0004);
        push_ev(EV_DONE, 32'h0, 32'h0, 32'h0, 1'b0);
        bus.desc_ready = 1'b0;
        pulse_start(32'h0C0);
        wait_desc_valid("t6_valid");
        stop_req = 1'b1;
        tick();
        bus.desc_ready = 1'b1;
        wait_idle("t6");
        stop_req = 1'b0;

        // Reset while responses are outstanding, then a stray response.
        fixed_dly = 3;
        push_reads(32'h000);
        pulse_start(32'h000);
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        check("rst_reads_issued", 32'(n < 40), 32'd1);
        reset = 1'b1;
        tick();
        check_reset_outputs("mid_rst");
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        inject      = 1'b1;
        inject_data = 32'hDEAD_BEEF;
        @(negedge clk);
        inject      = 1'b0;
        repeat (3) tick();
        check("rst_stray_src", bus.desc_src, 32'h0);
        check("rst_stray_busy", 32'(busy), 32'd0);
        check("rst_stray_valid", 32'(bus.desc_valid), 32'd0);
        fixed_dly = 0;

        // Recovery: descriptor at 0x0C0 was released by its write-back.
        push_reads(32'h0C0);
        push_ev(EV_DONE, 32'h0, 32'h0, 32'h0, 1'b0);
        pulse_start(32'h0C0);
        wait_idle("recover");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/descriptor_fetch_master.md
Name: descriptor_fetch_master

Overview:
Avalon-MM master that walks a chain of 4-word DMA descriptors held in on-chip descriptor memory.
- Fetches each descriptor and presents it on a valid/ready stream to the DMA datapath.
- After the datapath accepts a descriptor, writes back the descriptor's control word with OWNED cleared.
- Then follows the next pointer.
- Sits between the CPU-visible control registers and the descriptor memory slave port.

Parameters:
- ADDR_W, 32: byte-address width of the master port.
- LEN_W, 16: width of the transfer-length field.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begin chain at first_ptr. Ignored while busy.
- first_ptr  in  ADDR_W  byte address of the first descriptor.
- stop_req  in  1  level; halt at the next descriptor boundary.
- busy  out  1  high from the start-accept cycle until done/error.
- done  out  1  one-cycle pulse at normal chain end or stop.
- error  out  1  one-cycle pulse; next_ptr misaligned (bits [3:0] != 0).
- m_address  out  ADDR_W  byte address.
- m_read  out  1  Avalon read.
- m_write  out  1  Avalon write.
- m_byteenable  out  4  byte lanes.
- m_writedata  out  32  write data.
- m_readdata  in  32  read data.
- m_readdatavalid  in  1  read response strobe.
- m_waitrequest  in  1  slave stall.
- desc_valid  out  1  descriptor available.
- desc_ready  in  1  consumer accepts.
- desc_src  out  ADDR_W  word0, source address.
- desc_dst  out  ADDR_W  word1, destination address.
- desc_len  out  LEN_W  word3[LEN_W-1:0].
- desc_last  out  1  word3[30].

Behaviour:
- Descriptor layout, at base B (16-byte aligned):
  - B+0: src.
  - B+4: dst.
  - B+8: next_ptr.
  - B+12: control — bit31 OWNED, bit30 LAST, [LEN_W-1:0] length.
- Reset: busy, done, error, m_read, m_write, desc_valid = 0; m_byteenable = 4'hF; address/data registers = 0; FSM = IDLE. Read responses arriving after reset are discarded.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, CHECK, PRESENT, WB, NEXT.
- IDLE:
  - start -> latch first_ptr into cur_ptr, busy = 1, go to RD_ISSUE.
  - If first_ptr[3:0] != 0, pulse error instead and stay IDLE.
- RD_ISSUE:
  - Issue 4 pipelined reads at cur_ptr + 4*i, i = 0..3, with m_byteenable = 4'hF.
  - A read counts as issued only when m_read=1 and m_waitrequest=0; address holds while stalled.
  - Move to RD_WAIT after the 4th issue.
- RD_WAIT (issue and capture overlap):
  - Responses are captured in order by a 2-bit counter.
  - The 4th readdatavalid -> CHECK.
  - Up to 4 reads may be outstanding; no other limit.
- CHECK:
  - OWNED = 0 -> done pulse, busy = 0, IDLE. No write-back.
  - Otherwise -> PRESENT.
- PRESENT:
  - desc_valid = 1 with fields stable.
  - Transfer completes when desc_valid & desc_ready; desc_valid drops the next cycle.
  - desc_valid is never withdrawn before acceptance.
  - Then -> WB.
- WB:
  - Write m_address = cur_ptr+12, m_writedata = control & ~(1<<31), m_byteenable = 4'hF.
  - Hold m_write until m_waitrequest=0.
  - Then -> NEXT.
- NEXT, in priority order:
  1. LAST or stop_req -> done pulse, IDLE.
  2. next_ptr[3:0] != 0 -> error pulse, IDLE.
  3. Otherwise cur_ptr = next_ptr -> RD_ISSUE.
- Latency (zero-wait slave, 1-cycle read latency): start to desc_valid = 7 cycles.
- stop_req is sampled only in NEXT and never aborts an in-flight read or write.
- start while busy: ignored, no side effects.
- Address arithmetic is modulo 2^ADDR_W; wrap is not flagged.
- done and error are never asserted in the same cycle.
- Synchronous reset mid-transaction returns to IDLE immediately. The external fabric shares the same reset.

Decomposition:
- Package descriptor_fetch_pkg:
  - Word offset constants OFF_SRC=0, OFF_DST=4, OFF_NEXT=8, OFF_CTRL=12.
  - Bit constants CTRL_OWNED=31, CTRL_LAST=30.
  - DESC_WORDS = 4.
  - FSM state enum.
- One sub-module, desc_capture_regs: the 4x32 capture register file indexed by the response counter, with field extraction.

Test Plan:
1. Chain of one descriptor at 0x000: src=0x1000, dst=0x2000, len=0x0040, ctrl=0xC0000040; zero waitrequest; desc_ready=1.
   - desc_valid at cycle 7 with those fields.
   - Write of 0x40000040 to 0x00C.
   - done pulse; busy falls.
2. Two-descriptor chain 0x000 -> 0x010, second LAST; desc_ready held low 5 cycles on the first.
   - Fields stay stable while desc_valid is held.
   - Both descriptors are written back.
   - Exactly 2 accepts, then done.
3. Random m_waitrequest (50%) and 0–3-cycle readdatavalid delay.
   - Addresses are issued in order 0,4,8,C.
   - Captured fields match memory; no duplicate or missed reads.
4. First descriptor at 0x020 with ctrl=0x00000010 (OWNED=0).
   - done after the 4 reads.
   - No desc_valid and no m_write.
5. next_ptr=0x014.
   - After write-back of the first descriptor: error pulse, busy=0, no further reads.
   - start with first_ptr=0x008 -> immediate error.
6. stop_req asserted during PRESENT of a non-LAST descriptor.
   - Write-back still occurs, then done.
   - Reset asserted during RD_WAIT -> next cycle all outputs at reset values; late readdatavalid ignored.
